div_clk_serializer: RTL
=======================

# div_clk_serializer

Serial shift-out/shift-in engine that consumes the divided clock level produced by the clock divider stage and turns it into an SPI-mode-0-style link (SCLK, chip select, data out, data in). It runs entirely in the fast `i_clk` domain and uses edges of the divided clock as bit-rate enables. It sits directly downstream of the divider and upstream of off-chip serial peripherals. Each transaction is full-duplex: a parallel word goes out and a parallel word comes back.

## Interface
- `DATA_W`, default 8: word width in bits; must be ≥ 2.
- `MSB_FIRST`, default 1: 1 shifts bit `DATA_W-1` first; 0 shifts bit 0 first. Applies to both TX and RX.

One clock; reset is synchronous and active-high.
- `i_clk`, in, 1: system clock; all logic on its rising edge.
- `i_reset`, in, 1: synchronous active-high reset.
- `i_div_clk`, in, 1: divided clock level, registered in the `i_clk` domain; no synchronizer needed.
- `i_data`, in, `DATA_W`: TX word; sampled only on handshake.
- `i_valid`, in, 1: TX word request.
- `o_ready`, out, 1: high only in IDLE.
- `i_sdi`, in, 1: serial data from the peripheral.
- `o_sclk`, out, 1: serial clock.
- `o_sdo`, out, 1: serial data to the peripheral.
- `o_cs_n`, out, 1: active-low chip select.
- `o_rx_data`, out, `DATA_W`: last received word; holds until the next completion.
- `o_done`, out, 1: one-cycle completion pulse.

## Operation
- **Edge detection.** `div_prev` is `i_div_clk` registered; reset value 0.
  - Rise is `i_div_clk & ~div_prev`.
  - Fall is `~i_div_clk & div_prev`.
- **Bit counter.** Width `$clog2(DATA_W+1)`. Reset value 0.
- **FSM states.** IDLE, SETUP, SHIFT, DONE. Reset state is IDLE.
- **IDLE**
  - Outputs: `o_ready`=1, `o_cs_n`=1, `o_sclk`=0, `o_sdo`=0.
  - On `i_valid & o_ready`: latch `i_data` into the TX shift register, load the counter with `DATA_W`, and go to SETUP.
  - On that same edge, `o_cs_n`←0 and `o_sdo`←first bit.
- **SETUP**
  - `o_sclk` is held at 0.
  - Wait for a fall, then go to SHIFT.
  - A rise seen in SETUP is ignored. This guarantees a full low phase before the first SCLK rise.
- **SHIFT**
  - Every cycle, `o_sclk`←`i_div_clk`.
  - On a rise: counter decrements.
  - On a fall: shift `i_sdi` into the RX register, then branch on the counter:
    - counter==0: go to DONE and force `o_sclk`←0.
    - otherwise: `o_sdo`←next TX bit.
  - Exactly `DATA_W` SCLK rising edges and `DATA_W` RX samples occur per transaction.
- **DONE** (one cycle)
  - `o_cs_n`=1, `o_sclk`=0, `o_sdo`=0.
  - `o_rx_data`←RX register and `o_done`=1.
  - Then go to IDLE.
- **Ignored inputs.**
  - `i_valid` is ignored outside IDLE; no queuing.
  - Changes on `i_data` after the handshake are ignored.
- **Stalled divider.** If `i_div_clk` stops toggling, the FSM waits indefinitely. There is no timeout.
- **Reset.** `i_reset` wins over every other event at that edge.
  - Mid-transfer: the transfer aborts with no `o_done`.
  - Every output returns to its reset value: `o_ready`=1, `o_cs_n`=1, `o_sclk`=0, `o_sdo`=0, `o_done`=0, `o_rx_data`=0.

## Timing
- All outputs are registered; no combinational input-to-output paths.
- `o_sclk` lags `i_div_clk` by one `i_clk` cycle during SHIFT.
- `o_sdo` changes on the same `i_clk` edge where `o_sclk` falls. `i_sdi` is sampled on that same edge, i.e. at the end of the SCLK high phase.
- Handshake to `o_cs_n` low: 1 cycle.
- Duration, with divided clock half-period H cycles: the DONE pulse comes on the edge where the `DATA_W`-th SCLK high phase ends. Total `o_cs_n` low time is at most `(2·DATA_W+2)·H` cycles.
- Minimum `o_cs_n` high time between back-to-back transfers is 2 cycles: DONE, then the IDLE handshake.

## Test plan
- **MSB-first loopback.** Setup: `DATA_W`=8, `MSB_FIRST`=1, H=2, `i_sdi` tied to `o_sdo`. Send 0xC1.
  - `o_sdo` at the 8 SCLK rises reads 1,1,0,0,0,0,0,1.
  - Exactly 8 SCLK rises.
  - `o_rx_data`=0xC1 with a single `o_done` pulse.
- **LSB-first.** `MSB_FIRST`=0, send 0xC1.
  - `o_sdo` reads 1,0,0,0,0,0,1,1.
  - Loopback gives `o_rx_data`=0xC1.
  - With `i_sdi` held 1: `o_rx_data`=0xFF.
- **Busy rejection.** Pulse `i_valid` with 0xFF during SHIFT of 0x00.
  - `o_ready`=0 throughout, no effect on `o_sdo`.
  - Only one `o_done`; the next transfer starts only after a new handshake in IDLE.
- **Reset mid-transfer.** Assert `i_reset` after the 4th SCLK rise.
  - Next cycle: `o_cs_n`=1, `o_sclk`=0, `o_sdo`=0, `o_ready`=1, `o_done` never pulses.
  - A following 0xA5 transfer completes correctly.
- **Back-to-back.** `i_valid` held high with 0x5A, then 0x3C.
  - Two transfers, two `o_done` pulses.
  - `o_cs_n` high for exactly 2 cycles between them.
  - `o_rx_data` updates at each `o_done`.
- **Divider stall and phase.** Hold `i_div_clk`=1 for 100 cycles after the handshake: the FSM stays in SETUP with `o_sclk`=0. On release the transfer completes normally. Also start with `i_div_clk` high at handshake: no SCLK rise before the first fall.

Source files
------------

// File: rtl/div_clk_serializer.sv
// div_clk_serializer: full-duplex SPI mode-0 shifter clocked by edges of a divided clock level
module div_clk_serializer #(
  parameter int DATA_W = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_div_clk,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic              i_sdi,
  output logic              o_sclk,
  output logic              o_sdo,
  output logic              o_cs_n,
  output logic [DATA_W-1:0] o_rx_data,
  output logic              o_done
);
  localparam int CW = $clog2(DATA_W + 1);
  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, DONE} state_t;
  state_t state, state_n;
  logic div_prev, rise, fall;
  logic [CW-1:0] cnt;
  logic [DATA_W-1:0] tx_sr, rx_sr, rx_next;
  always_comb begin
    rise = i_div_clk & ~div_prev;
    fall = ~i_div_clk & div_prev;
    o_ready = state == IDLE;
    rx_next = MSB_FIRST ? {rx_sr[DATA_W-2:0], i_sdi} : {i_sdi, rx_sr[DATA_W-1:1]};
    state_n = state;
    case (state)
      IDLE:    state_n = i_valid ? SETUP : IDLE;
      SETUP:   state_n = fall ? SHIFT : SETUP;
      SHIFT:   state_n = (fall && cnt == '0) ? DONE : SHIFT;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state     <= IDLE;
      div_prev  <= 1'b0;
      cnt       <= '0;
      tx_sr     <= '0;
      rx_sr     <= '0;
      o_rx_data <= '0;
      o_sclk    <= 1'b0;
      o_sdo     <= 1'b0;
      o_cs_n    <= 1'b1;
      o_done    <= 1'b0;
    end else begin
      state    <= state_n;
      div_prev <= i_div_clk;
      o_done   <= 1'b0;
      if (o_ready && i_valid) begin
        tx_sr  <= i_data;
        cnt    <= CW'(DATA_W);
        o_cs_n <= 1'b0;
        o_sdo  <= MSB_FIRST ? i_data[DATA_W-1] : i_data[0];
      end
      if (state == SHIFT) begin
        o_sclk <= i_div_clk;
        if (rise) cnt <= cnt - CW'(1);
        if (fall) begin
          rx_sr <= rx_next;
          if (cnt == '0) begin
            o_sclk    <= 1'b0;
            o_cs_n    <= 1'b1;
            o_sdo     <= 1'b0;
            o_done    <= 1'b1;
            o_rx_data <= rx_next;
          end else begin
            tx_sr <= MSB_FIRST ? tx_sr << 1 : tx_sr >> 1;
            o_sdo <= MSB_FIRST ? tx_sr[DATA_W-2] : tx_sr[1];
          end
        end
      end
    end
  end
endmodule
